// File: rtl/regfile_read_pipe.sv
// regfile_read_pipe: flop register file, one write port, two registered read ports with stall hold.
// Define REGFILE_BYPASS_EN to forward same-edge write data to a matching read port.
module regfile_read_pipe #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              ren,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [WIDTH-1:0]  rdata_a,
   output logic [WIDTH-1:0]  rdata_b,
   output logic              rvalid
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rv_a, rv_b, nxt_a, nxt_b;
   // entry 0 is never enabled, so it stays at its cleared value of zero
   always_ff @(posedge clk or posedge clr)
      if (clr)
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      else
         for (int k = 1; k < DEPTH; k++)
            if (we && waddr == ADDR_W'(k)) mem[k] <= wdata;
   // addresses at or beyond DEPTH match no entry and read as zero
   always_comb begin
      rv_a = '0;
      rv_b = '0;
      for (int k = 1; k < DEPTH; k++) begin
         if (raddr_a == ADDR_W'(k)) rv_a = mem[k];
         if (raddr_b == ADDR_W'(k)) rv_b = mem[k];
      end
   end
`ifdef REGFILE_BYPASS_EN
   logic wr_ok;
   assign wr_ok = we && waddr != '0 && 32'(waddr) < DEPTH;
   assign nxt_a = (wr_ok && raddr_a == waddr) ? wdata : rv_a;
   assign nxt_b = (wr_ok && raddr_b == waddr) ? wdata : rv_b;
`else
   assign nxt_a = rv_a;
   assign nxt_b = rv_b;
`endif
   always_ff @(posedge clk or posedge clr)
      if (clr) begin
         rdata_a <= '0;
         rdata_b <= '0;
         rvalid  <= 1'b0;
      end else begin
         rvalid <= ren;
         if (ren) begin
            rdata_a <= nxt_a;
            rdata_b <= nxt_b;
         end
      end
endmodule

// File: tb/tb_regfile_read_pipe.sv
// tb_regfile_read_pipe: directed and random checks of regfile_read_pipe against an array model.
module tb_regfile_read_pipe;
   localparam int WIDTH = 32, DEPTH = 32, ADDR_W = 5;
   logic clk, clr, we, ren;
   logic [ADDR_W-1:0] waddr, raddr_a, raddr_b;
   logic [WIDTH-1:0] wdata, rdata_a, rdata_b;
   logic rvalid;
   int checks = 0, errors = 0;
   logic [WIDTH-1:0] model [DEPTH];
   logic [WIDTH-1:0] exp_a, exp_b;
   logic exp_v;

   regfile_read_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .ren(ren),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b), .rvalid(rvalid)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] val(input int addr, input logic w, input int wa, input logic [WIDTH-1:0] wd);
      if (addr == 0 || addr >= DEPTH) return '0;
`ifdef REGFILE_BYPASS_EN
      if (w && addr == wa) return wd;
`endif
      return model[addr];
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      exp_a = '0;
      exp_b = '0;
      exp_v = 1'b0;
   endfunction

   task automatic step(input logic w, input int wa, input logic [WIDTH-1:0] wd,
                       input logic r, input int a, input int b);
      @(negedge clk);
      we = w; waddr = ADDR_W'(wa); wdata = wd;
      ren = r; raddr_a = ADDR_W'(a); raddr_b = ADDR_W'(b);
      @(posedge clk);
      if (r) begin
         exp_a = val(a, w, wa, wd);
         exp_b = val(b, w, wa, wd);
      end
      exp_v = r;
      if (w && wa != 0 && wa < DEPTH) model[wa] = wd;
      #1;
      chk("rdata_a", rdata_a, exp_a);
      chk("rdata_b", rdata_b, exp_b);
      chk("rvalid", {31'b0, rvalid}, {31'b0, exp_v});
   endtask

   initial begin
      clr = 1; we = 0; ren = 0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
      model_clear();
      #12;
      chk("reset_rdata_a", rdata_a, '0);
      chk("reset_rvalid", {31'b0, rvalid}, 32'd0);
      @(negedge clk);
      clr = 0;
      // fill some registers and read them so the clear has live state to wipe
      for (int i = 1; i < 8; i++) step(1, i, $urandom, 1, i - 1, 31);
      step(0, 0, 0, 1, 5, 3);
      @(negedge clk);
      clr = 1;
      #1;
      chk("clr_async_rvalid", {31'b0, rvalid}, 32'd0);
      chk("clr_async_rdata_a", rdata_a, '0);
      chk("clr_async_rdata_b", rdata_b, '0);
      model_clear();
      @(posedge clk);
      #2 clr = 0;
      step(0, 0, 0, 1, 5, 31);
      chk("post_clr_a5", rdata_a, '0);
      chk("post_clr_valid", {31'b0, rvalid}, 32'd1);
      // write then read back, port B on register 0
      step(1, 7, 32'hDEADBEEF, 0, 0, 0);
      step(0, 0, 0, 1, 7, 0);
      chk("rd7_a", rdata_a, 32'hDEADBEEF);
      chk("rd0_b", rdata_b, '0);
      // register 0 ignores writes
      step(1, 0, 32'h12345678, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      chk("r0_a", rdata_a, '0);
      // same-edge write and read of register 3
      step(1, 3, 32'h1, 0, 0, 0);
      step(1, 3, 32'h2, 1, 3, 3);
`ifdef REGFILE_BYPASS_EN
      chk("same_edge_a", rdata_a, 32'h2);
      chk("same_edge_b", rdata_b, 32'h2);
`else
      chk("same_edge_a", rdata_a, 32'h1);
      chk("same_edge_b", rdata_b, 32'h1);
`endif
      step(0, 0, 0, 1, 3, 3);
      chk("next_read_3", rdata_b, 32'h2);
      // stall holds outputs while the register underneath changes
      step(0, 0, 0, 1, 7, 7);
      step(1, 7, 32'hA5A5A5A5, 0, 7, 7);
      step(0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 2, 2);
      chk("stall_hold_a", rdata_a, 32'hDEADBEEF);
      step(0, 0, 0, 1, 7, 7);
      chk("after_stall_a", rdata_a, 32'hA5A5A5A5);
      // back-to-back reads
      for (int i = 1; i <= 4; i++) step(1, i, 10 * i, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         step(0, 0, 0, 1, i, 5 - i);
         chk("b2b_a", rdata_a, 10 * i);
      end
      // random traffic, with deliberate address collisions
      for (int n = 0; n < 300; n++) begin
         int wa, a, b;
         wa = $urandom_range(0, DEPTH - 1);
         a = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH - 1);
         b = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH - 1);
         step($urandom_range(0, 1), wa, $urandom, $urandom_range(0, 3) != 0, a, b);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_read_pipe.md
Name: regfile_read_pipe

Overview:
- Flop-based register file with one write port and two registered read ports.
- Read ports drive the decode/operand-fetch pipeline latch, so the read side and the storage share one clock and one async clear.
- Storage is built from enable-gated flops with async clear, one per bit.
- The read side captures operands on a handshake-qualified edge and holds them during stalls.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of registers; register 0 reads as 0.
- ADDR_W, 5, address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- clr  input  1  reset, asynchronous, active-high.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  WIDTH  write data.
- ren  input  1  read request; 0 = stall, hold outputs.
- raddr_a  input  ADDR_W  read address, port A.
- raddr_b  input  ADDR_W  read address, port B.
- rdata_a  output  WIDTH  registered read data, port A.
- rdata_b  output  WIDTH  registered read data, port B.
- rvalid  output  1  high for the cycle in which rdata_a/rdata_b reflect a request.

Behaviour:
- Reset (clr=1, asynchronous, immediate):
  - all storage registers = 0;
  - rdata_a = 0, rdata_b = 0, rvalid = 0;
  - clr dominates clk, we and ren.
- Write:
  - At posedge with we=1 and waddr != 0 and waddr < DEPTH, reg[waddr] <= wdata.
  - Writes to address 0 or to an address >= DEPTH are ignored.
- Read:
  - At posedge with ren=1, rdata_a <= value(raddr_a), rdata_b <= value(raddr_b), and rvalid <= 1.
  - Latency is exactly 1 cycle from request to data.
- Stall:
  - At posedge with ren=0, rdata_a and rdata_b hold their previous values; rvalid <= 0.
- value(addr):
  - 0 when addr == 0 or addr >= DEPTH;
  - otherwise reg[addr] as stored before the current edge, unless the bypass rule applies (see Optional Feature).
- Both ports may read the same address in the same cycle; both return the identical value.
- Back-to-back ren=1 gives one result per cycle, with rvalid held high continuously.
- clr asserted mid-operation:
  - any in-flight read result is discarded (rvalid=0);
  - the first read after clr deasserts returns 0 for every address.
- Simultaneous we and ren to different addresses: independent; the write is visible to reads issued on the next cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When we=1, ren=1 and raddr_x == waddr != 0 on the same edge, rdata_x <= wdata (write-through).
  - Applies per port independently.
- Not defined:
  - On that same edge, rdata_x <= old reg[waddr].
  - The new value becomes visible on the following read.
- Address 0 is never bypassed in either build.

Test Plan:
- clr pulse mid-cycle, then ren=1 with raddr_a=5, raddr_b=31 -> rdata_a=0, rdata_b=0, rvalid=1 one cycle after the request; during clr, rvalid=0 immediately.
- we=1, waddr=7, wdata=32'hDEADBEEF; next cycle ren=1, raddr_a=7, raddr_b=0 -> rdata_a=32'hDEADBEEF, rdata_b=0.
- we=1, waddr=0, wdata=32'h12345678; then read addr 0 on both ports -> 0 on both.
- Reg 3 = 32'h1; on the same edge issue we=1, waddr=3, wdata=32'h2 and ren=1, raddr_a=3, raddr_b=3 -> with REGFILE_BYPASS_EN, both ports = 32'h2; without it, both = 32'h1; a read on the next cycle returns 32'h2 in both builds.
- Read addr 7 (ren=1), then ren=0 for 3 cycles while writing reg 7 = 32'hA5A5A5A5 -> rdata_a holds 32'hDEADBEEF and rvalid=0 throughout the stall; the next ren=1 returns 32'hA5A5A5A5.
- ren=1 for 4 consecutive cycles with raddr_a = 1, 2, 3, 4 preloaded to 10, 20, 30, 40 -> rdata_a = 10, 20, 30, 40 on successive cycles, with rvalid held at 1.
